calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Parametrised, fully synchronous successor to the calculator operand/state controller. It synchronises and edge-detects the raw enter button and latches two operands of `DATA_W` bits. It issues a start/done handshake to the arithmetic unit, guards that handshake with a timeout, and holds the result for chained operations. An error state drives the display and LEDs. It sits between the keypad/BCD entry path (`in_val`) and the ALU, and drives the 7-segment display mux select and status LEDs.

## Interface
- `DATA_W`, 40: operand/result width in bits.
- `SYNC_STAGES`, 2: flip-flop stages in the enter-button synchroniser (minimum 2).
- `ALU_TIMEOUT`, 255: cycles spent in WAIT without `alu_done` before entering ERR. Must be ≥1.

- `clk`  in  1  system clock; all state is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enter_button`  in  1  raw asynchronous button level.
- `enable_switch`  in  1  when low, enter events are discarded.
- `in_val`  in  DATA_W  operand currently keyed in.
- `alu_result`  in  DATA_W  ALU result magnitude.
- `alu_sign`  in  1  ALU result sign.
- `alu_done`  in  1  one-cycle ALU completion strobe.
- `alu_err`  in  1  ALU error flag; sampled only together with `alu_done`.
- `op_a`, `op_b`  out  DATA_W  registered ALU operands.
- `alu_start`  out  1  one-cycle start pulse to the ALU.
- `result`  out  DATA_W  last valid result, registered.
- `o_sign`  out  1  sign of `result`.
- `busy`  out  1  high while in WAIT.
- `display_sel`  out  2  display select: 00 = entry 1, 01 = entry 2/continue, 11 = result, 10 = error.
- `led`  out  4  state indicator.

## Operation
- Enter path:
  - `enter_button` passes through `SYNC_STAGES` flops, then a one-flop edge register.
  - `enter_evt` is asserted for one cycle on a synchronised 0→1 transition.
  - An event is acted on only if `enable_switch` = 1 in the same cycle.
- States:
  - IN1: `display_sel` 00, `led` 0001.
    - On event: `op_a` ← `in_val`, `o_sign` ← 0, go to IN2.
  - IN2: `display_sel` 01, `led` 0010.
    - On event: `op_b` ← `in_val`, `alu_start` = 1 for the next cycle, timer ← 0, go to WAIT.
  - WAIT: `display_sel` 01, `led` 0011, `busy` = 1. Enter events are dropped, not queued.
    - `alu_done` with `alu_err` = 0: `result` ← `alu_result`, `o_sign` ← `alu_sign`, go to RES.
    - `alu_done` with `alu_err` = 1: go to ERR.
    - If the timer reaches `ALU_TIMEOUT` with no `alu_done`: go to ERR.
    - `alu_done` wins over a timeout in the same cycle.
  - RES: `display_sel` 11, `led` 0100.
    - On event: `op_a` ← `result` (chaining), go to CONT.
  - CONT: `display_sel` 01, `led` 1000.
    - On event: `op_b` ← `in_val`, issue `alu_start`, go to WAIT.
  - ERR: `display_sel` 10, `led` 1111.
    - On event: `op_a`, `op_b`, `result`, `o_sign` ← 0, go to IN1.
- `alu_done` is ignored outside WAIT, including the cycle in which `alu_start` is high.
- Timer width is `$clog2(ALU_TIMEOUT+1)`. It saturates and never wraps.
- Undefined state encodings recover to IN1 on the next clock.

## Timing
- Reset: state IN1, `op_a` = `op_b` = `result` = 0, `o_sign` = 0, `alu_start` = 0, `busy` = 0, `display_sel` = 00, `led` = 0000. `led` stays 0000 until the first state change.
- Synchroniser and edge flops are also cleared. A button already held through reset release produces no event.
- Button-to-action latency: press level to `enter_evt` is `SYNC_STAGES`+1 cycles. State and outputs update on the following edge.
- `alu_start` is high for exactly the first cycle in WAIT. `op_a` and `op_b` are stable from that cycle until WAIT exits.
- On a done strobe, RES outputs appear one cycle after the `alu_done` cycle.
- On a timeout, ERR is entered on the edge after the timer reaches `ALU_TIMEOUT`, i.e. `ALU_TIMEOUT`+1 cycles after `alu_start`.
- Reset asserted mid-WAIT aborts the operation. A later `alu_done` is ignored because the block is then in IN1.
- Reset has priority over every other input in the same cycle.

## Test plan
- Basic flow: reset, then enter with `in_val` = 12, then enter with `in_val` = 30. Expect one `alu_start` pulse, `op_a` = 12, `op_b` = 30. ALU returns 42 with sign 0 after 5 cycles. Expect `result` = 42, `display_sel` 11, `led` 0100.
- Chaining: from RES with `result` = 42, press enter twice with `in_val` = 8. Expect `op_a` = 42, `op_b` = 8, `alu_start` pulsed. ALU returns 34 with sign 1. Expect `o_sign` = 1.
- Timeout: `ALU_TIMEOUT` = 4, no `alu_done`. Expect ERR (`led` 1111, `display_sel` 10) exactly 5 cycles after `alu_start`. Then enter: expect IN1 with all operands 0.
- ALU error: `alu_done` = 1 with `alu_err` = 1. Expect ERR and `result` unchanged.
- Gating and drops: hold `enable_switch` = 0 and press enter 3 times; state stays IN1. Press enter during WAIT; it is dropped and no second `alu_start` occurs. A 1-cycle glitch shorter than the synchroniser window followed by a long press gives exactly one event.
- Reset mid-WAIT: assert `reset` 2 cycles after `alu_start`, then pulse `alu_done`. Expect IN1, all outputs at reset values, and no change to `result`.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: synchronises the enter button and sequences operand capture,
// the ALU start/done handshake (with timeout), result chaining and error recovery.
module calc_sequencer #(
    parameter int unsigned DATA_W      = 40,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter_button,
    input  logic              enable_switch,
    input  logic [DATA_W-1:0] in_val,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_sign,
    input  logic              alu_done,
    input  logic              alu_err,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              alu_start,
    output logic [DATA_W-1:0] result,
    output logic              o_sign,
    output logic              busy,
    output logic [1:0]        display_sel,
    output logic [3:0]        led
);

    localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(ALU_TIMEOUT);

    typedef enum logic [2:0] {
        S_IN1  = 3'd0,
        S_IN2  = 3'd1,
        S_WAIT = 3'd2,
        S_RES  = 3'd3,
        S_CONT = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TW-1:0]          r_timer;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_evt;
    logic                   w_sync;
    logic                   w_fire;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_fire = r_evt & enable_switch;

    // r_armed only rises once a genuine (post-reset) low level has been seen,
    // so a button held through reset release cannot produce an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], enter_button};
            r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_sync;
            r_armed <= r_armed | (r_vld[SYNC_STAGES-1] & ~w_sync);
            r_evt   <= r_armed & w_sync & ~r_prev;
        end
    end

    function automatic logic [1:0] f_disp(input state_t s);
        case (s)
            S_IN1:   return 2'b00;
            S_RES:   return 2'b11;
            S_ERR:   return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [3:0] f_led(input state_t s);
        case (s)
            S_IN1:   return 4'b0001;
            S_IN2:   return 4'b0010;
            S_WAIT:  return 4'b0011;
            S_RES:   return 4'b0100;
            S_CONT:  return 4'b1000;
            default: return 4'b1111;
        endcase
    endfunction

    // alu_done is ignored in the start cycle; a done strobe beats a coincident timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IN1:  if (w_fire) w_next = S_IN2;
            S_IN2:  if (w_fire) w_next = S_WAIT;
            S_WAIT: begin
                if (!alu_start && alu_done) w_next = alu_err ? S_ERR : S_RES;
                else if (r_timer == TMAX)   w_next = S_ERR;
            end
            S_RES:  if (w_fire) w_next = S_CONT;
            S_CONT: if (w_fire) w_next = S_WAIT;
            S_ERR:  if (w_fire) w_next = S_IN1;
            default: w_next = S_IN1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IN1;
            r_timer     <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            o_sign      <= 1'b0;
            alu_start   <= 1'b0;
            busy        <= 1'b0;
            display_sel <= 2'b00;
            led         <= 4'b0000;
        end else begin
            r_state     <= w_next;
            alu_start   <= (w_next == S_WAIT) && (r_state != S_WAIT);
            busy        <= (w_next == S_WAIT);
            display_sel <= f_disp(w_next);
            if (w_next != r_state) led <= f_led(w_next);

            if (r_state == S_WAIT) r_timer <= (r_timer == TMAX) ? r_timer : r_timer + TW'(1);
            else                   r_timer <= '0;

            case (r_state)
                S_IN1: if (w_fire) begin
                    op_a   <= in_val;
                    o_sign <= 1'b0;
                end
                S_IN2:  if (w_fire) op_b <= in_val;
                S_WAIT: if (!alu_start && alu_done && !alu_err) begin
                    result <= alu_result;
                    o_sign <= alu_sign;
                end
                S_RES:  if (w_fire) op_a <= result;
                S_CONT: if (w_fire) op_b <= in_val;
                S_ERR:  if (w_fire) begin
                    op_a   <= '0;
                    op_b   <= '0;
                    result <= '0;
                    o_sign <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: two instances (long and short ALU timeout) share stimulus
// and are compared every cycle against a transaction-level model, plus directed checks.
module tb_calc_sequencer;

    localparam int DW = 40;
    localparam int SS = 2;
    localparam int unsigned TO0 = 16;
    localparam int unsigned TO1 = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enter_button = 1'b1;
    logic          enable_switch = 1'b1;
    logic [DW-1:0] in_val = '0;
    logic [DW-1:0] alu_result = '0;
    logic          alu_sign = 1'b0;
    logic          alu_done = 1'b0;
    logic          alu_err = 1'b0;

    logic [DW-1:0] op_a[2], op_b[2], result[2];
    logic          alu_start[2], o_sign[2], busy[2];
    logic [1:0]    display_sel[2];
    logic [3:0]    led[2];

    calc_sequencer #(.DATA_W(DW), .SYNC_STAGES(SS), .ALU_TIMEOUT(TO0)) u_dut0 (
        .clk(clk), .reset(reset), .enter_button(enter_button), .enable_switch(enable_switch),
        .in_val(in_val), .alu_result(alu_result), .alu_sign(alu_sign), .alu_done(alu_done),
        .alu_err(alu_err), .op_a(op_a[0]), .op_b(op_b[0]), .alu_start(alu_start[0]),
        .result(result[0]), .o_sign(o_sign[0]), .busy(busy[0]),
        .display_sel(display_sel[0]), .led(led[0]));

    calc_sequencer #(.DATA_W(DW), .SYNC_STAGES(SS), .ALU_TIMEOUT(TO1)) u_dut1 (
        .clk(clk), .reset(reset), .enter_button(enter_button), .enable_switch(enable_switch),
        .in_val(in_val), .alu_result(alu_result), .alu_sign(alu_sign), .alu_done(alu_done),
        .alu_err(alu_err), .op_a(op_a[1]), .op_b(op_b[1]), .alu_start(alu_start[1]),
        .result(result[1]), .o_sign(o_sign[1]), .busy(busy[1]),
        .display_sel(display_sel[1]), .led(led[1]));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int starts0 = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IN1, M_IN2, M_WAIT, M_RES, M_CONT, M_ERR} mode_t;
    mode_t         m_mode[2];
    logic [DW-1:0] m_a[2], m_b[2], m_res[2];
    bit            m_sign[2], m_start[2], m_moved[2];
    int            m_wcnt[2];
    bit            samp[$];   // button level seen at each clock edge since reset
    int            m_n;
    bit            m_fire;
    mode_t         m_prev;

    function automatic int unsigned tmo(int i);
        return (i == 0) ? TO0 : TO1;
    endfunction

    function automatic logic [1:0] exp_disp(mode_t m);
        case (m)
            M_IN1:   return 2'b00;
            M_RES:   return 2'b11;
            M_ERR:   return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [3:0] exp_led(mode_t m, bit moved);
        if (!moved) return 4'h0;
        case (m)
            M_IN1:   return 4'h1;
            M_IN2:   return 4'h2;
            M_WAIT:  return 4'h3;
            M_RES:   return 4'h4;
            M_CONT:  return 4'h8;
            default: return 4'hF;
        endcase
    endfunction

    // An event is visible SS+1 cycles after the edge where the button was first
    // seen high, provided it was seen low at the previous post-reset edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = M_IN1; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
                m_sign[i] = 0; m_start[i] = 0; m_moved[i] = 0; m_wcnt[i] = 0;
            end
            samp.delete();
        end else begin
            m_n = samp.size();
            m_fire = (m_n >= SS + 2) && samp[m_n-SS-1] && !samp[m_n-SS-2] && enable_switch;
            for (int i = 0; i < 2; i++) begin
                m_prev = m_mode[i];
                m_start[i] = 0;
                case (m_mode[i])
                    M_IN1: if (m_fire) begin m_a[i] = in_val; m_sign[i] = 0; m_mode[i] = M_IN2; end
                    M_IN2, M_CONT: if (m_fire) begin
                        m_b[i] = in_val; m_mode[i] = M_WAIT; m_start[i] = 1; m_wcnt[i] = 0;
                    end
                    M_WAIT: begin
                        if (m_wcnt[i] > 0 && alu_done) begin
                            if (alu_err) m_mode[i] = M_ERR;
                            else begin m_res[i] = alu_result; m_sign[i] = alu_sign; m_mode[i] = M_RES; end
                        end else if (m_wcnt[i] == int'(tmo(i))) m_mode[i] = M_ERR;
                        else m_wcnt[i]++;
                    end
                    M_RES: if (m_fire) begin m_a[i] = m_res[i]; m_mode[i] = M_CONT; end
                    default: if (m_fire) begin
                        m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_sign[i] = 0; m_mode[i] = M_IN1;
                    end
                endcase
                if (m_mode[i] != m_prev) m_moved[i] = 1;
            end
            samp.push_back(enter_button);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic tick();
        logic [128:0] got, exp;
        @(posedge clk); #1;
        cyc++;
        if (alu_start[0] === 1'b1) starts0++;
        for (int i = 0; i < 2; i++) begin
            got = {op_a[i], op_b[i], result[i], o_sign[i], alu_start[i], busy[i], display_sel[i], led[i]};
            exp = {m_a[i], m_b[i], m_res[i], m_sign[i], m_start[i], (m_mode[i] == M_WAIT),
                   exp_disp(m_mode[i]), exp_led(m_mode[i], m_moved[i])};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL model dut%0d cyc %0d: got a=%h b=%h r=%h s=%b st=%b bz=%b d=%b l=%b, want a=%h b=%h r=%h s=%b st=%b bz=%b d=%b l=%b",
                         i, cyc, op_a[i], op_b[i], result[i], o_sign[i], alu_start[i], busy[i],
                         display_sel[i], led[i], m_a[i], m_b[i], m_res[i], m_sign[i], m_start[i],
                         (m_mode[i] == M_WAIT), exp_disp(m_mode[i]), exp_led(m_mode[i], m_moved[i]));
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1; enter_button = 0; alu_done = 0; alu_err = 0;
        tick(); tick();
        reset = 0;
        repeat (SS + 3) tick();
    endtask

    task automatic press(input logic [DW-1:0] v);
        in_val = v; enter_button = 1;
        repeat (SS + 3) tick();
        enter_button = 0;
        repeat (SS + 2) tick();
    endtask

    // Presses until dut0 shows alu_start; returns in the first WAIT cycle.
    task automatic press_start(input logic [DW-1:0] v);
        bit ok = 0;
        in_val = v; enter_button = 1;
        for (int k = 0; k < SS + 6 && !ok; k++) begin
            tick();
            if (alu_start[0] === 1'b1) ok = 1;
        end
        enter_button = 0;
        chk("start_pulse_seen", ok, 1);
    endtask

    task automatic alu_reply(input int d, input logic [DW-1:0] r, input bit s, input bit e);
        repeat (d) tick();
        alu_result = r; alu_sign = s; alu_err = e; alu_done = 1;
        tick();
        alu_done = 0; alu_err = 0;
    endtask

    typedef struct {
        logic [DW-1:0] a, b, r;
        int            d;
        bit            s, e;
        logic [3:0]    xled;
        logic [DW-1:0] xres;
        bit            xsign;
    } vec_t;

    vec_t vecs[4];
    int   s_before;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // d = 4 on the short-timeout instance checks that done beats a coincident timeout
        vecs[0] = '{a: 5,   b: 7,   r: 12,              d: 1, s: 0, e: 0, xled: 4'h4, xres: 12,              xsign: 0};
        vecs[1] = '{a: 40'hFF_FFFF_FFFF, b: 1, r: 40'h80_0000_0000, d: 4, s: 1, e: 0, xled: 4'h4, xres: 40'h80_0000_0000, xsign: 1};
        vecs[2] = '{a: 3,   b: 3,   r: 9,               d: 2, s: 1, e: 1, xled: 4'hF, xres: 0,               xsign: 0};
        vecs[3] = '{a: 100, b: 200, r: 40'hAB_CDEF_0123, d: 3, s: 0, e: 0, xled: 4'h4, xres: 40'hAB_CDEF_0123, xsign: 0};

        // Reset values; button held through reset release gives no event
        tick(); tick();
        chk("rst_led", led[0], 4'h0);
        chk("rst_disp", display_sel[0], 2'b00);
        chk("rst_opa", op_a[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_start", alu_start[0], 0);
        reset = 0;
        repeat (8) tick();
        chk("held_through_reset_led", led[0], 4'h0);
        enter_button = 0;
        repeat (4) tick();
        chk("held_release_led", led[0], 4'h0);

        // Gating
        enable_switch = 0;
        repeat (3) press(55);
        chk("gated_led", led[0], 4'h0);
        chk("gated_opa", op_a[0], 0);
        enable_switch = 1;

        // Basic flow with latency check
        in_val = 12; enter_button = 1;
        repeat (SS + 1) tick();
        chk("latency_before", led[0], 4'h0);
        tick();
        chk("latency_after", led[0], 4'h2);
        chk("basic_opa", op_a[0], 12);
        enter_button = 0;
        repeat (SS + 2) tick();
        s_before = starts0;
        press_start(30);
        chk("basic_opb", op_b[0], 30);
        chk("basic_busy", busy[0], 1);
        alu_reply(5, 42, 0, 0);
        chk("basic_result", result[0], 42);
        chk("basic_disp", display_sel[0], 2'b11);
        chk("basic_led", led[0], 4'h4);
        chk("basic_one_start", starts0 - s_before, 1);

        // Chaining
        press(8);
        chk("chain_opa", op_a[0], 42);
        chk("chain_led", led[0], 4'h8);
        press_start(8);
        chk("chain_opb", op_b[0], 8);
        alu_reply(3, 34, 1, 0);
        chk("chain_result", result[0], 34);
        chk("chain_sign", o_sign[0], 1);

        // ALU error keeps result; ERR recovery clears
        press(9);
        press_start(9);
        alu_reply(2, 77, 0, 1);
        chk("aluerr_led", led[0], 4'hF);
        chk("aluerr_disp", display_sel[0], 2'b10);
        chk("aluerr_result_kept", result[0], 34);
        press(0);
        chk("recover_led", led[0], 4'h1);
        chk("recover_opa", op_a[0], 0);
        chk("recover_opb", op_b[0], 0);
        chk("recover_result", result[0], 0);
        chk("recover_sign", o_sign[0], 0);

        // Done in start cycle ignored; press during WAIT dropped
        press(21);
        press_start(4);
        alu_result = 77; alu_done = 1;
        tick();
        alu_done = 0;
        chk("done_in_start_ignored", busy[0], 1);
        s_before = starts0;
        press(50);
        chk("wait_drop_no_start", starts0 - s_before, 0);
        chk("wait_drop_busy", busy[0], 1);
        chk("wait_opb_stable", op_b[0], 4);
        alu_reply(1, 25, 0, 0);
        chk("after_drop_result", result[0], 25);

        // Timeout on the short-timeout instance
        do_reset();
        press(6);
        press_start(7);
        repeat (TO1) tick();
        chk("to_still_wait", led[1], 4'h3);
        tick();
        chk("to_err_led", led[1], 4'hF);
        chk("to_err_disp", display_sel[1], 2'b10);
        press(1);
        chk("to_recover_led", led[1], 4'h1);
        chk("to_recover_opa", op_a[1], 0);
        chk("to_recover_opb", op_b[1], 0);

        // Reset mid-WAIT
        do_reset();
        press(11);
        press_start(13);
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        alu_result = 99; alu_done = 1;
        tick();
        alu_done = 0;
        tick();
        chk("midrst_led", led[0], 4'h0);
        chk("midrst_disp", display_sel[0], 2'b00);
        chk("midrst_result", result[0], 0);
        chk("midrst_opa", op_a[0], 0);
        chk("midrst_busy", busy[0], 0);

        // Sub-cycle glitch then long press: exactly one event
        do_reset();
        tick();
        #2 enter_button = 1;
        #2 enter_button = 0;
        repeat (4) tick();
        press(60);
        chk("glitch_led", led[0], 4'h2);
        chk("glitch_opa", op_a[0], 60);

        // Table-driven operations
        for (int v = 0; v < 4; v++) begin
            do_reset();
            press(vecs[v].a);
            press_start(vecs[v].b);
            alu_reply(vecs[v].d, vecs[v].r, vecs[v].s, vecs[v].e);
            chk($sformatf("vec%0d_opa", v), op_a[0], vecs[v].a);
            chk($sformatf("vec%0d_opb", v), op_b[0], vecs[v].b);
            chk($sformatf("vec%0d_result", v), result[0], vecs[v].xres);
            chk($sformatf("vec%0d_sign", v), o_sign[0], vecs[v].xsign);
            chk($sformatf("vec%0d_led", v), led[0], vecs[v].xled);
            chk($sformatf("vec%0d_led_t4", v), led[1], vecs[v].xled);
        end

        // Randomised run against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            reset         = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) enter_button = ~enter_button;
            enable_switch = ($urandom_range(0, 7) != 0);
            in_val        = DW'({$urandom(), $urandom()});
            alu_result    = DW'({$urandom(), $urandom()});
            alu_sign      = $urandom_range(0, 1);
            alu_done      = ($urandom_range(0, 4) == 0);
            alu_err       = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
